// File: rtl/reg_writeback_queue.sv
// In-order writeback queue between the MEM stage and the register-file write port.
// Optional macro WB_BYPASS_EN adds a forwarding lookup over pending writes.
module reg_writeback_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ADDR_W-1:0]         in_rt,
  input  logic [ADDR_W-1:0]         in_rd,
  input  logic [DATA_W-1:0]         in_alu_result,
  input  logic [DATA_W-1:0]         in_mem_data,
  input  logic                      in_reg_write,
  input  logic                      in_reg_dst,
  input  logic                      in_mem_to_reg,
  input  logic                      in_link,
  input  logic                      rf_busy,
  output logic                      wb_reg_write,
  output logic [ADDR_W-1:0]         wb_write_reg,
  output logic [DATA_W-1:0]         wb_write_data,
  output logic [$clog2(DEPTH):0]    wb_count,
  input  logic [ADDR_W-1:0]         fwd_addr,
  output logic                      fwd_hit,
  output logic [DATA_W-1:0]         fwd_data
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_mem_reg  [DEPTH];
  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic [ADDR_W-1:0] w_dest;
  logic [DATA_W-1:0] w_data;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;

  // Destination/data selection; link overrides the other muxes.
  assign w_dest = in_link ? ADDR_W'(31) : (in_reg_dst ? in_rd : in_rt);
  assign w_data = (in_link || !in_mem_to_reg) ? in_alu_result : in_mem_data;

  assign in_ready = !rst && (r_count < CNT_W'(DEPTH));
  assign w_accept = in_valid && in_ready;
  assign w_push   = w_accept && in_reg_write && (w_dest != '0);
  assign w_pop    = (r_count != '0) && !rf_busy;
  assign wb_count = r_count;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_reg[r_tail]  <= w_dest;
      r_mem_data[r_tail] <= w_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      wb_reg_write  <= 1'b0;
      wb_write_reg  <= '0;
      wb_write_data <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop) begin
        r_head        <= r_head + PTR_W'(1);
        wb_write_reg  <= r_mem_reg[r_head];
        wb_write_data <= r_mem_data[r_head];
      end
      wb_reg_write <= w_pop;
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end

`ifdef WB_BYPASS_EN
  logic [PTR_W-1:0] w_idx;

  // Scan oldest to newest so the newest matching entry wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    w_idx    = r_head;
    if (fwd_addr != '0) begin
      if (wb_reg_write && (wb_write_reg == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_write_data;
      end
      for (int i = 0; i < int'(DEPTH); i++) begin
        w_idx = r_head + PTR_W'(i);
        if ((CNT_W'(i) < r_count) && (r_mem_reg[w_idx] == fwd_addr)) begin
          fwd_hit  = 1'b1;
          fwd_data = r_mem_data[w_idx];
        end
      end
    end
  end
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^fwd_addr;
  assign fwd_hit      = 1'b0;
  assign fwd_data     = '0;
`endif

endmodule

// File: doc/reg_writeback_queue.md
Name: reg_writeback_queue

Overview:
- Write-side producer for the register file: takes retired results from the memory stage and selects destination register and write data.
- Buffers results in a small in-order queue and drains one write per cycle onto the register-file write port (write_data / write_reg / regWrite).
- Optional forwarding lookup lets the read side see values still pending in the queue.
- Sits between the MEM stage and the register file.

Parameters:
DEPTH, 4, queue entries (power of two, ≥2)
DATA_W, 32, data width
ADDR_W, 5, register index width

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  MEM stage presents a result
in_ready  output  1  queue can accept this cycle
in_rt  input  ADDR_W  rt field
in_rd  input  ADDR_W  rd field
in_alu_result  input  DATA_W  ALU result (or link address)
in_mem_data  input  DATA_W  load data
in_reg_write  input  1  instruction writes a register
in_reg_dst  input  1  1: dest=rd, 0: dest=rt
in_mem_to_reg  input  1  1: data=in_mem_data, 0: in_alu_result
in_link  input  1  jal: dest=31, data=in_alu_result (overrides reg_dst/mem_to_reg)
rf_busy  input  1  register-file write port unavailable this cycle
wb_reg_write  output  1  write strobe to register file
wb_write_reg  output  ADDR_W  write address
wb_write_data  output  DATA_W  write data
wb_count  output  $clog2(DEPTH)+1  entries pending
fwd_addr  input  ADDR_W  lookup address (WB_BYPASS_EN only)
fwd_hit  output  1  pending value exists for fwd_addr
fwd_data  output  DATA_W  newest pending value for fwd_addr

Behaviour:
- Reset (async, rst=1): head/tail pointers=0, wb_count=0, wb_reg_write=0, wb_write_reg=0, wb_write_data=0, fwd_hit=0, fwd_data=0.
- in_ready is forced 0 while rst=1; otherwise in_ready = (wb_count < DEPTH). It is combinational from registered count only; a drain in the same cycle does not raise it.
- Accept = in_valid & in_ready at rising edge.
- Destination register: in_link ? 31 : (in_reg_dst ? in_rd : in_rt).
- Write data: in_link ? in_alu_result : (in_mem_to_reg ? in_mem_data : in_alu_result).
- An accepted result with in_reg_write=0, or with computed destination 0, is consumed but not enqueued. $0 is never written.
- Drain: at each edge with wb_count>0 and rf_busy=0, the head is popped into wb_write_reg/wb_write_data and wb_reg_write=1 for the following cycle.
- Otherwise wb_reg_write=0 and wb_write_reg/wb_write_data hold their last values.
- wb_reg_write is a one-cycle strobe per entry; it never stays high across two cycles for the same entry.
- Latency: result accepted at edge N into an empty queue → wb_reg_write high in cycle after edge N+1 (2 edges minimum).
- Ordering is strictly FIFO; back-to-back writes to the same register drain oldest first.
- Simultaneous enqueue and drain: wb_count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- rf_busy held: queue fills to DEPTH, then in_ready=0. No entry is lost or duplicated.
- Reset mid-operation discards all pending entries; no strobe is issued for them.

Optional Feature:
WB_BYPASS_EN
- Defined: fwd_hit/fwd_data are combinational over all valid queue entries plus the wb output register while wb_reg_write=1.
  - The newest matching entry wins; the wb output register is the oldest.
  - fwd_addr=0 never hits.
  - The current in_* input is not searched.
- Not defined: fwd_addr is ignored, fwd_hit=0 and fwd_data=0 constantly, and no comparator logic is generated.

Test Plan:
- Reset, then send rt=8, reg_dst=0, mem_to_reg=0, alu=0x0000_0005 → exactly one wb_reg_write pulse, two edges later, with reg=8, data=5; wb_count returns to 0.
- Send rd=3, reg_dst=1, mem_to_reg=1, mem=0xDEAD_BEEF, then a link with alu=0x0040_0010 → writes reg 3=0xDEADBEEF, then reg 31=0x00400010, in order.
- Hold rf_busy=1 and offer 6 writes → 4 accepted, in_ready=0; release rf_busy → 4 consecutive strobes in FIFO order, then the remaining 2 are accepted.
- Send dest=0 writes and in_reg_write=0 writes → handshakes complete, wb_count stays 0, no strobe.
- WB_BYPASS_EN: queue reg 7=1 then reg 7=2 with rf_busy=1, fwd_addr=7 → fwd_hit=1, fwd_data=2; fwd_addr=0 → fwd_hit=0.
- Assert rst with 3 entries pending and rf_busy=0 → wb_reg_write=0 immediately, wb_count=0, and no strobe after reset release.
